risc_v_id_ex_stage: RTL and testbench
=====================================

Name: risc_v_id_ex_stage

Overview:
ID/EX pipeline register plus execute-side operand forwarding. It sits directly upstream of the ALU. It captures decoded operands and control at the end of decode, supports stall (hold) and flush (bubble), and drives SrcA/SrcB/ALUControl into the ALU. SrcA and SrcB are forwarded from the MEM and WB stages.

Parameters:
XLEN, 32, datapath width (ALU is 32-bit; only 32 is supported)
REG_AW, 5, register-index width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
stall_e  in  1  hold all E-stage registers
flush_e  in  1  load a bubble into the E stage
valid_d  in  1  decode slot holds a real instruction
rd1_d, rd2_d  in  XLEN  register-file read data
imm_ext_d, pc_d  in  XLEN  sign-extended immediate; PC
rs1_d, rs2_d, rd_d  in  REG_AW  source and destination indices
alu_control_d  in  3  ALU op (ADD 000, SUB 001, AND 010, OR 011, SLT 101)
alu_src_d  in  1  1 = SrcB takes the immediate
reg_write_d, mem_write_d  in  1  write enables
result_src_d  in  2  WB result select
alu_result_m, result_w  in  XLEN  forwarding sources
rd_m, rd_w  in  REG_AW  MEM/WB destinations
reg_write_m, reg_write_w  in  1  MEM/WB write enables
src_a_e, src_b_e  out  XLEN  ALU operands
write_data_e  out  XLEN  forwarded rs2 value for stores
alu_control_e  out  3  to ALU
pc_e, imm_ext_e  out  XLEN  registered PC and immediate
rs1_e, rs2_e, rd_e  out  REG_AW  to hazard unit and pipeline
reg_write_e, mem_write_e, valid_e  out  1  registered control
result_src_e  out  2  registered
forward_a_e, forward_b_e  out  2  mux selects (00 register, 01 WB, 10 MEM)

Behaviour:
- Register update priority on each rising clk: reset > flush_e > stall_e > load.
- reset: all registered fields go to 0. This makes alu_control_e = ADD, valid_e = 0, and all write enables 0.
- flush_e: behaves like reset for one cycle, inserting a bubble. flush_e beats stall_e when both are asserted.
- stall_e (no flush): every register holds its value. Forwarding still re-evaluates each cycle against the current M/W inputs.
- Load: every *_d input is captured into its *_e register. There is 1-cycle latency from D to E.
- If valid_d = 0 on a load, the stage captures a bubble: reg_write_e = 0, mem_write_e = 0, valid_e = 0. Data fields may be captured as-is.
- Forwarding is combinational from the registered E fields and the M/W inputs. It has no added latency.
  - forward_a_e = 10 if reg_write_m and rd_m != 0 and rd_m == rs1_e.
  - Otherwise forward_a_e = 01 if reg_write_w and rd_w != 0 and rd_w == rs1_e.
  - Otherwise forward_a_e = 00.
  - forward_b_e uses the same rules with rs2_e.
  - MEM has priority over WB. x0 is never forwarded.
- Operand muxes:
  - src_a_e is rd1_e, result_w or alu_result_m, chosen by forward_a_e.
  - write_data_e is the same 3:1 selection over rd2_e, chosen by forward_b_e.
  - src_b_e = alu_src_e ? imm_ext_e : write_data_e.
- Selects 11 are unreachable. The mux default is the register value.
- Outputs are purely functions of the E registers and the M/W inputs. There are no combinational paths from *_d inputs to outputs.
- Load-use hazards are out of scope. The hazard unit drives stall_e/flush_e.

Optional Feature:
Macro RISC_V_ID_EX_PERF_EN.
- Defined: adds two output ports, bubble_cnt_e [31:0] and stall_cnt_e [31:0].
  - bubble_cnt_e increments on each clock where a flush occurs or an invalid instruction is loaded.
  - stall_cnt_e increments on each clock with stall_e = 1 and flush_e = 0.
  - Both counters wrap modulo 2^32, are cleared by reset, and hold during reset.
- Undefined: both ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package risc_v_pkg holds:
  - alu_ctrl_t enum: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
  - fwd_sel_t enum: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - XLEN and REG_AW default constants.
- One sub-module, risc_v_forward_unit, is combinational. It takes rs1_e, rs2_e, rd_m, rd_w, reg_write_m and reg_write_w, and produces forward_a_e and forward_b_e.

Test Plan:
- Reset with all *_d inputs nonzero: the cycle after reset deasserts shows all outputs 0, alu_control_e = 000 and valid_e = 0.
- Load rd1_d = 5, rd2_d = 7, alu_control_d = 001, valid_d = 1, with no M/W matches: the next cycle shows src_a_e = 5, src_b_e = 7, alu_control_e = 001.
- Stall: after a load with rd1_d = 0x10, set stall_e = 1 for 3 cycles while changing rd1_d to 0x20. src_a_e stays 0x10; the first cycle after release shows 0x20.
- Flush and stall together with reg_write_d = 1: the next cycle shows reg_write_e = 0, valid_e = 0, alu_control_e = 000.
- Forward priority with rs1_e = 3, rd_m = 3, rd_w = 3, both write enables 1, alu_result_m = 0xAA, result_w = 0xBB: src_a_e = 0xAA, forward_a_e = 10. Dropping reg_write_m gives 0xBB and 01.
- x0 and immediate with rs2_e = 0, rd_m = 0, reg_write_m = 1: forward_b_e = 00. With alu_src = 1 and imm_ext = 0xFFFFFFFC, src_b_e = 0xFFFFFFFC while write_data_e stays the forwarded rs2 value.

Source files
------------

// File: rtl/risc_v_pkg.sv
// risc_v_pkg: shared types and default widths for the ID/EX stage slice.
//   alu_ctrl_t : ALU operation encodings driven on alu_control_e
//   fwd_sel_t  : operand forwarding mux selects
//   XLEN/REG_AW: default datapath and register-index widths
package risc_v_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

endpackage

// File: rtl/risc_v_forward_unit.sv
// risc_v_forward_unit: combinational forwarding-select logic for the E stage.
// Ports:
//   rs1_e, rs2_e           in  E-stage source indices
//   rd_m, rd_w             in  MEM/WB destination indices
//   reg_write_m/_w         in  MEM/WB write enables
//   forward_a_e/_b_e       out 00 register, 01 WB, 10 MEM (MEM wins, x0 never forwarded)
module risc_v_forward_unit #(
  parameter int unsigned REG_AW = risc_v_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e
);
  import risc_v_pkg::*;

  fwd_sel_t w_fwd_a;
  fwd_sel_t w_fwd_b;

  always_comb begin
    w_fwd_a = FWD_REG;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))
      w_fwd_a = FWD_MEM;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e))
      w_fwd_a = FWD_WB;
  end

  always_comb begin
    w_fwd_b = FWD_REG;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))
      w_fwd_b = FWD_MEM;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e))
      w_fwd_b = FWD_WB;
  end

  assign forward_a_e = w_fwd_a;
  assign forward_b_e = w_fwd_b;

endmodule

// File: rtl/risc_v_id_ex_stage.sv
// risc_v_id_ex_stage: ID/EX pipeline register with E-stage operand forwarding.
// Register priority per clock: reset > flush_e > stall_e > load. A load with
// valid_d = 0 captures a bubble (write enables and valid cleared).
// Ports:
//   clk, reset (sync, active-high), stall_e, flush_e, valid_d
//   *_d      decoded operands/control from ID
//   *_m/*_w  forwarding sources from MEM/WB
//   src_a_e, src_b_e, write_data_e, alu_control_e to ALU/store path
//   pc_e, imm_ext_e, rs1_e, rs2_e, rd_e, reg_write_e, mem_write_e,
//   valid_e, result_src_e, forward_a_e, forward_b_e
// Optional: RISC_V_ID_EX_PERF_EN adds bubble_cnt_e/stall_cnt_e counters.
module risc_v_id_ex_stage #(
  parameter int unsigned XLEN   = risc_v_pkg::XLEN,
  parameter int unsigned REG_AW = risc_v_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic              valid_d,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [XLEN-1:0]   imm_ext_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic [2:0]        alu_control_d,
  input  logic              alu_src_d,
  input  logic              reg_write_d,
  input  logic              mem_write_d,
  input  logic [1:0]        result_src_d,
  input  logic [XLEN-1:0]   alu_result_m,
  input  logic [XLEN-1:0]   result_w,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  output logic [XLEN-1:0]   src_a_e,
  output logic [XLEN-1:0]   src_b_e,
  output logic [XLEN-1:0]   write_data_e,
  output logic [2:0]        alu_control_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   imm_ext_e,
  output logic [REG_AW-1:0] rs1_e,
  output logic [REG_AW-1:0] rs2_e,
  output logic [REG_AW-1:0] rd_e,
  output logic              reg_write_e,
  output logic              mem_write_e,
  output logic              valid_e,
  output logic [1:0]        result_src_e,
`ifdef RISC_V_ID_EX_PERF_EN
  output logic [31:0]       bubble_cnt_e,
  output logic [31:0]       stall_cnt_e,
`endif
  output logic [1:0]        forward_a_e,
  output logic [1:0]        forward_b_e
);
  import risc_v_pkg::*;

  logic [XLEN-1:0]   r_rd1;
  logic [XLEN-1:0]   r_rd2;
  logic [XLEN-1:0]   r_imm;
  logic [XLEN-1:0]   r_pc;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  logic [2:0]        r_alu_control;
  logic              r_alu_src;
  logic              r_reg_write;
  logic              r_mem_write;
  logic              r_valid;
  logic [1:0]        r_result_src;

  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;
  logic [XLEN-1:0]   w_src_a;
  logic [XLEN-1:0]   w_write_data;

  // Flush shares the reset path: a bubble is the all-zero register image.
  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      r_rd1         <= '0;
      r_rd2         <= '0;
      r_imm         <= '0;
      r_pc          <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rd          <= '0;
      r_alu_control <= ALU_ADD;
      r_alu_src     <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_write   <= 1'b0;
      r_valid       <= 1'b0;
      r_result_src  <= '0;
    end else if (!stall_e) begin
      r_rd1         <= rd1_d;
      r_rd2         <= rd2_d;
      r_imm         <= imm_ext_d;
      r_pc          <= pc_d;
      r_rs1         <= rs1_d;
      r_rs2         <= rs2_d;
      r_rd          <= rd_d;
      r_alu_control <= alu_control_d;
      r_alu_src     <= alu_src_d;
      r_reg_write   <= reg_write_d & valid_d;
      r_mem_write   <= mem_write_d & valid_d;
      r_valid       <= valid_d;
      r_result_src  <= result_src_d;
    end
  end

`ifdef RISC_V_ID_EX_PERF_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (flush_e || (!stall_e && !valid_d))
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      if (stall_e && !flush_e)
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bubble_cnt_e = r_bubble_cnt;
  assign stall_cnt_e  = r_stall_cnt;
`endif

  risc_v_forward_unit #(.REG_AW(REG_AW)) u_fwd (
    .rs1_e       (r_rs1),
    .rs2_e       (r_rs2),
    .rd_m        (rd_m),
    .rd_w        (rd_w),
    .reg_write_m (reg_write_m),
    .reg_write_w (reg_write_w),
    .forward_a_e (w_fwd_a),
    .forward_b_e (w_fwd_b)
  );

  always_comb begin
    case (w_fwd_a)
      FWD_WB:  w_src_a = result_w;
      FWD_MEM: w_src_a = alu_result_m;
      default: w_src_a = r_rd1;
    endcase
  end

  always_comb begin
    case (w_fwd_b)
      FWD_WB:  w_write_data = result_w;
      FWD_MEM: w_write_data = alu_result_m;
      default: w_write_data = r_rd2;
    endcase
  end

  assign src_a_e       = w_src_a;
  assign write_data_e  = w_write_data;
  assign src_b_e       = r_alu_src ? r_imm : w_write_data;
  assign alu_control_e = r_alu_control;
  assign pc_e          = r_pc;
  assign imm_ext_e     = r_imm;
  assign rs1_e         = r_rs1;
  assign rs2_e         = r_rs2;
  assign rd_e          = r_rd;
  assign reg_write_e   = r_reg_write;
  assign mem_write_e   = r_mem_write;
  assign valid_e       = r_valid;
  assign result_src_e  = r_result_src;
  assign forward_a_e   = w_fwd_a;
  assign forward_b_e   = w_fwd_b;

endmodule

// File: tb/tb_risc_v_id_ex_stage.sv
// Scoreboard bench for risc_v_id_ex_stage: stimulus pushes named expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_risc_v_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall_e, flush_e, valid_d;
  logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [2:0]  alu_control_d;
  logic        alu_src_d, reg_write_d, mem_write_d;
  logic [1:0]  result_src_d;
  logic [31:0] alu_result_m, result_w;
  logic [4:0]  rd_m, rd_w;
  logic        reg_write_m, reg_write_w;
  logic [31:0] src_a_e, src_b_e, write_data_e, pc_e, imm_ext_e;
  logic [2:0]  alu_control_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        reg_write_e, mem_write_e, valid_e;
  logic [1:0]  result_src_e, forward_a_e, forward_b_e;
`ifdef RISC_V_ID_EX_PERF_EN
  logic [31:0] bubble_cnt_e, stall_cnt_e;
`endif

  always #5 clk = ~clk;

  risc_v_id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e), .valid_d(valid_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_ext_d(imm_ext_d), .pc_d(pc_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .alu_control_d(alu_control_d),
    .alu_src_d(alu_src_d), .reg_write_d(reg_write_d), .mem_write_d(mem_write_d),
    .result_src_d(result_src_d), .alu_result_m(alu_result_m), .result_w(result_w),
    .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .src_a_e(src_a_e), .src_b_e(src_b_e), .write_data_e(write_data_e),
    .alu_control_e(alu_control_e), .pc_e(pc_e), .imm_ext_e(imm_ext_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e), .reg_write_e(reg_write_e),
    .mem_write_e(mem_write_e), .valid_e(valid_e), .result_src_e(result_src_e),
`ifdef RISC_V_ID_EX_PERF_EN
    .bubble_cnt_e(bubble_cnt_e), .stall_cnt_e(stall_cnt_e),
`endif
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e)
  );

  string       q_name[$];
  logic [31:0] q_exp[$];
  int          n_total = 0;
  int          n_pass  = 0;

  function automatic logic [31:0] actual(input string n);
    case (n)
      "src_a":      return src_a_e;
      "src_b":      return src_b_e;
      "write_data": return write_data_e;
      "alu_ctrl":   return {29'd0, alu_control_e};
      "pc":         return pc_e;
      "imm":        return imm_ext_e;
      "rs1":        return {27'd0, rs1_e};
      "rd":         return {27'd0, rd_e};
      "reg_write":  return {31'd0, reg_write_e};
      "mem_write":  return {31'd0, mem_write_e};
      "valid":      return {31'd0, valid_e};
      "result_src": return {30'd0, result_src_e};
      "fwd_a":      return {30'd0, forward_a_e};
      "fwd_b":      return {30'd0, forward_b_e};
`ifdef RISC_V_ID_EX_PERF_EN
      "bubble_cnt": return bubble_cnt_e;
      "stall_cnt":  return stall_cnt_e;
`endif
      default:      return 'x;
    endcase
  endfunction

  // Monitor: outputs are sampled on the falling edge, mid-cycle.
  always @(negedge clk) begin
    while (q_name.size() > 0) begin
      string       n;
      logic [31:0] e, a;
      n = q_name.pop_front();
      e = q_exp.pop_front();
      a = actual(n);
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", n, a, e, $time);
    end
  end

  task automatic expect_val(input string n, input logic [31:0] v);
    q_name.push_back(n);
    q_exp.push_back(v);
  endtask

  // Inputs are applied after a falling edge; expectations are pushed just after
  // the rising edge and checked at the next falling edge.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; stall_e = 1'b0; flush_e = 1'b0; valid_d = 1'b1;
    rd1_d = 32'h1111_1111; rd2_d = 32'h2222_2222; imm_ext_d = 32'h33; pc_d = 32'h44;
    rs1_d = 5'd1; rs2_d = 5'd2; rd_d = 5'd3; alu_control_d = 3'b011;
    alu_src_d = 1'b1; reg_write_d = 1'b1; mem_write_d = 1'b1; result_src_d = 2'b11;
    alu_result_m = '0; result_w = '0; rd_m = '0; rd_w = '0;
    reg_write_m = 1'b0; reg_write_w = 1'b0;

    // Reset with nonzero decode inputs
    step(); step();
    expect_val("src_a", 0); expect_val("src_b", 0); expect_val("write_data", 0);
    expect_val("alu_ctrl", 0); expect_val("valid", 0); expect_val("reg_write", 0);
    expect_val("mem_write", 0); expect_val("pc", 0); expect_val("imm", 0);
    expect_val("rd", 0); expect_val("result_src", 0); expect_val("fwd_a", 0);
`ifdef RISC_V_ID_EX_PERF_EN
    expect_val("bubble_cnt", 0); expect_val("stall_cnt", 0);
`endif
    settle();

    // Basic load, no forwarding matches
    reset = 1'b0; rd1_d = 32'd5; rd2_d = 32'd7; alu_control_d = 3'b001; alu_src_d = 1'b0;
    rs1_d = 5'd1; rs2_d = 5'd2; rd_d = 5'd4; mem_write_d = 1'b0; result_src_d = 2'b01;
    pc_d = 32'h100; imm_ext_d = 32'h8;
    step();
    expect_val("src_a", 5); expect_val("src_b", 7); expect_val("alu_ctrl", 1);
    expect_val("valid", 1); expect_val("reg_write", 1); expect_val("rd", 4);
    expect_val("pc", 32'h100); expect_val("result_src", 1); expect_val("fwd_a", 0);
    settle();

    // Stall holds, forwarding still live during stall
    rd1_d = 32'h10;
    step(); expect_val("src_a", 32'h10); settle();
    stall_e = 1'b1; rd1_d = 32'h20;
    step(); expect_val("src_a", 32'h10); settle();
    rd_m = 5'd1; reg_write_m = 1'b1; alu_result_m = 32'h55;
    step(); expect_val("src_a", 32'h55); expect_val("fwd_a", 2); settle();
    rd_m = 5'd0; reg_write_m = 1'b0; alu_result_m = '0;
    step(); expect_val("src_a", 32'h10); expect_val("fwd_a", 0);
`ifdef RISC_V_ID_EX_PERF_EN
    expect_val("stall_cnt", 3);
`endif
    settle();
    stall_e = 1'b0;
    step(); expect_val("src_a", 32'h20); settle();

    // Invalid instruction load becomes a bubble, data still captured
    valid_d = 1'b0; mem_write_d = 1'b1; rd1_d = 32'h30;
    step();
    expect_val("reg_write", 0); expect_val("mem_write", 0); expect_val("valid", 0);
    expect_val("src_a", 32'h30);
`ifdef RISC_V_ID_EX_PERF_EN
    expect_val("bubble_cnt", 1);
`endif
    settle();

    // Flush beats stall
    valid_d = 1'b1; mem_write_d = 1'b0; stall_e = 1'b1; flush_e = 1'b1;
    step();
    expect_val("reg_write", 0); expect_val("valid", 0); expect_val("alu_ctrl", 0);
    expect_val("src_a", 0);
`ifdef RISC_V_ID_EX_PERF_EN
    expect_val("bubble_cnt", 2); expect_val("stall_cnt", 3);
`endif
    settle();

    // Forward priority MEM over WB, then WB once MEM drops
    stall_e = 1'b0; flush_e = 1'b0;
    rs1_d = 5'd3; rs2_d = 5'd5; rd1_d = 32'h1; rd2_d = 32'h2; alu_src_d = 1'b0;
    rd_m = 5'd3; rd_w = 5'd3; reg_write_m = 1'b1; reg_write_w = 1'b1;
    alu_result_m = 32'hAA; result_w = 32'hBB;
    step();
    expect_val("src_a", 32'hAA); expect_val("fwd_a", 2);
    expect_val("src_b", 32'h2); expect_val("fwd_b", 0); expect_val("rs1", 3);
    settle();
    stall_e = 1'b1; reg_write_m = 1'b0;
    step();
    expect_val("src_a", 32'hBB); expect_val("fwd_a", 1);
`ifdef RISC_V_ID_EX_PERF_EN
    expect_val("stall_cnt", 4);
`endif
    settle();

    // x0 never forwarded; immediate selects SrcB
    stall_e = 1'b0; rs1_d = 5'd6; rs2_d = 5'd0; rd2_d = 32'h77;
    alu_src_d = 1'b1; imm_ext_d = 32'hFFFF_FFFC;
    rd_m = 5'd0; reg_write_m = 1'b1; rd_w = 5'd0; reg_write_w = 1'b1;
    step();
    expect_val("fwd_b", 0); expect_val("src_b", 32'hFFFF_FFFC);
    expect_val("write_data", 32'h77); expect_val("imm", 32'hFFFF_FFFC);
    settle();

    // Immediate on SrcB while store data is forwarded from WB
    rs2_d = 5'd9; rd_w = 5'd9;
    step();
    expect_val("fwd_b", 1); expect_val("src_b", 32'hFFFF_FFFC);
    expect_val("write_data", 32'hBB);
    settle();

    // Reset again mid-run
    reset = 1'b1;
    step();
    expect_val("valid", 0); expect_val("src_b", 32'h0); expect_val("alu_ctrl", 0);
`ifdef RISC_V_ID_EX_PERF_EN
    expect_val("bubble_cnt", 0); expect_val("stall_cnt", 0);
`endif
    settle();

    // Bounded drain of any pending expectations
    for (int i = 0; i < 10 && q_name.size() > 0; i++) @(negedge clk);
    #1;
    if (q_name.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0", q_name.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
